// File: rtl/nf_pkg.sv
// Shared definitions for the mean-filter noise datapath: mode encoding and
// width helpers used by the neighbour classifier and its pixel classifier.
package nf_pkg;

  localparam logic [1:0] MODE_PEPPER = 2'b00;
  localparam logic [1:0] MODE_SALT   = 2'b01;
  localparam logic [1:0] MODE_BOTH   = 2'b10;

  // Neighbours summed per first-level adder group.
  localparam int GRP_SZ = 4;

  // Bits needed to hold a count from 0 to n inclusive.
  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction

  // Modes 10 and 11 both treat either noise type as noisy.
  function automatic logic is_noisy(input logic pepper, input logic salt,
                                    input logic [1:0] mode);
    case (mode)
      MODE_PEPPER:     return pepper;
      MODE_SALT:       return salt;
      MODE_BOTH, 2'b11: return pepper | salt;
      default:         return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/pix_classify.sv
// Combinational salt/pepper classification of a single pixel; pepper takes
// precedence when degenerate thresholds make both conditions true.
module pix_classify
  import nf_pkg::*;
#(
  parameter int PIX_W     = 8,
  parameter int PEPPER_TH = 0,
  parameter int SALT_TH   = 255
) (
  input  logic [PIX_W-1:0] pix,
  input  logic [1:0]       mode,
  output logic             pepper,
  output logic             salt,
  output logic             noisy
);

  localparam logic [PIX_W-1:0] PEPPER_V = PIX_W'(PEPPER_TH);
  localparam logic [PIX_W-1:0] SALT_V   = PIX_W'(SALT_TH);

  assign pepper = (pix <= PEPPER_V);
  assign salt   = !pepper && (pix >= SALT_V);
  assign noisy  = is_noisy(pepper, salt, mode);

endmodule

// File: rtl/noise_nbr_counter.sv
// Three-stage valid/ready salt-and-pepper neighbour classifier: counts pepper,
// salt and noisy neighbours, sums the clean ones and flags the centre pixel.
module noise_nbr_counter
  import nf_pkg::*;
#(
  parameter  int PIX_W     = 8,
  parameter  int N_NBR     = 8,
  parameter  int PEPPER_TH = 0,
  parameter  int SALT_TH   = 2**PIX_W - 1,
  localparam int CW        = cnt_w(N_NBR),
  localparam int SW        = PIX_W + CW
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [1:0]             in_mode,
  input  logic [PIX_W-1:0]       in_ctr,
  input  logic [N_NBR*PIX_W-1:0] in_nbr,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [PIX_W-1:0]       out_ctr,
  output logic                   out_ctr_noisy,
  output logic [CW-1:0]          out_n_pepper,
  output logic [CW-1:0]          out_n_salt,
  output logic [CW-1:0]          out_n_noisy,
  output logic [SW-1:0]          out_clean_sum,
  output logic                   out_all_noisy
);

  localparam int N_GRP = (N_NBR + GRP_SZ - 1) / GRP_SZ;
  localparam int GCW   = cnt_w(GRP_SZ);
  localparam int GSW   = PIX_W + $clog2(GRP_SZ);

  typedef struct packed {
    logic [N_NBR-1:0]       pep;
    logic [N_NBR-1:0]       salt;
    logic [N_NBR*PIX_W-1:0] pix;
    logic [PIX_W-1:0]       ctr;
    logic                   ctr_noisy;
    logic [1:0]             mode;
  } s1_t;

  typedef struct packed {
    logic [N_GRP-1:0][GCW-1:0] pep;
    logic [N_GRP-1:0][GCW-1:0] salt;
    logic [N_GRP-1:0][GCW-1:0] noisy;
    logic [N_GRP-1:0][GSW-1:0] sum;
    logic [PIX_W-1:0]          ctr;
    logic                      ctr_noisy;
  } s2_t;

  typedef struct packed {
    logic [CW-1:0]    pep;
    logic [CW-1:0]    salt;
    logic [CW-1:0]    noisy;
    logic [SW-1:0]    sum;
    logic [PIX_W-1:0] ctr;
    logic             ctr_noisy;
    logic             all_noisy;
  } s3_t;

  logic s1_v_q, s1_v_d, s2_v_q, s2_v_d, s3_v_q, s3_v_d;
  logic s1_en, s2_en, s3_en;
  s1_t  s1_q, s1_d, s1_n;
  s2_t  s2_q, s2_d, s2_n;
  s3_t  s3_q, s3_d, s3_n;

  // ---------------------------------------------------------------- classify
  logic [N_NBR-1:0] nbr_pep, nbr_salt, nbr_noisy;
  logic             ctr_noisy;
  logic             ctr_pep_unused, ctr_salt_unused;

  for (genvar k = 0; k < N_NBR; k++) begin : g_nbr
    pix_classify #(.PIX_W(PIX_W), .PEPPER_TH(PEPPER_TH), .SALT_TH(SALT_TH)) u_cls (
      .pix    (in_nbr[k*PIX_W +: PIX_W]),
      .mode   (in_mode),
      .pepper (nbr_pep[k]),
      .salt   (nbr_salt[k]),
      .noisy  (nbr_noisy[k])
    );
  end

  pix_classify #(.PIX_W(PIX_W), .PEPPER_TH(PEPPER_TH), .SALT_TH(SALT_TH)) u_ctr_cls (
    .pix    (in_ctr),
    .mode   (in_mode),
    .pepper (ctr_pep_unused),
    .salt   (ctr_salt_unused),
    .noisy  (ctr_noisy)
  );

  // Noisy neighbours are zeroed here so later stages just add everything.
  always_comb begin
    // NOTE: assigning a default first means every path writes s1_n, so no latch is inferred.
    s1_n           = '0;
    s1_n.pep       = nbr_pep;
    s1_n.salt      = nbr_salt;
    s1_n.ctr       = in_ctr;
    s1_n.ctr_noisy = ctr_noisy;
    s1_n.mode      = in_mode;
    for (int k = 0; k < N_NBR; k++) begin
      if (!nbr_noisy[k]) s1_n.pix[k*PIX_W +: PIX_W] = in_nbr[k*PIX_W +: PIX_W];
    end
  end

  // ------------------------------------------------- first-level group sums
  logic [N_GRP-1:0][GCW-1:0] grp_pep, grp_salt, grp_noisy;
  logic [N_GRP-1:0][GSW-1:0] grp_sum;

  for (genvar g = 0; g < N_GRP; g++) begin : g_grp
    localparam int BASE  = g * GRP_SZ;
    localparam int G_LEN = (N_NBR - BASE < GRP_SZ) ? N_NBR - BASE : GRP_SZ;

    logic [GCW-1:0] pep_c, salt_c, noisy_c;
    logic [GSW-1:0] sum_c;

    always_comb begin
      pep_c   = '0;
      salt_c  = '0;
      noisy_c = '0;
      sum_c   = '0;
      for (int j = 0; j < G_LEN; j++) begin
        pep_c   = pep_c  + GCW'(s1_q.pep[BASE+j]);
        salt_c  = salt_c + GCW'(s1_q.salt[BASE+j]);
        noisy_c = noisy_c + GCW'(is_noisy(s1_q.pep[BASE+j], s1_q.salt[BASE+j], s1_q.mode));
        sum_c   = sum_c + GSW'(s1_q.pix[(BASE+j)*PIX_W +: PIX_W]);
      end
    end

    assign grp_pep[g]   = pep_c;
    assign grp_salt[g]  = salt_c;
    assign grp_noisy[g] = noisy_c;
    assign grp_sum[g]   = sum_c;
  end

  always_comb begin
    s2_n           = '0;
    s2_n.pep       = grp_pep;
    s2_n.salt      = grp_salt;
    s2_n.noisy     = grp_noisy;
    s2_n.sum       = grp_sum;
    s2_n.ctr       = s1_q.ctr;
    s2_n.ctr_noisy = s1_q.ctr_noisy;
  end

  // ------------------------------------------------------------------ totals
  always_comb begin
    s3_n = '0;
    for (int g = 0; g < N_GRP; g++) begin
      s3_n.pep   = s3_n.pep   + CW'(s2_q.pep[g]);
      s3_n.salt  = s3_n.salt  + CW'(s2_q.salt[g]);
      s3_n.noisy = s3_n.noisy + CW'(s2_q.noisy[g]);
      s3_n.sum   = s3_n.sum   + SW'(s2_q.sum[g]);
    end
    s3_n.ctr       = s2_q.ctr;
    s3_n.ctr_noisy = s2_q.ctr_noisy;
    s3_n.all_noisy = (s3_n.noisy == CW'(N_NBR));
  end

  // ------------------------------------------------------- pipeline control
  // A stage may load when empty or when its current content leaves this cycle.
  always_comb begin
    s3_en  = !s3_v_q || out_ready;
    s2_en  = !s2_v_q || s3_en;
    s1_en  = !s1_v_q || s2_en;

    s1_v_d = s1_en ? in_valid : s1_v_q;
    s2_v_d = s2_en ? s1_v_q   : s2_v_q;
    s3_v_d = s3_en ? s2_v_q   : s3_v_q;

    s1_d   = (s1_en && in_valid) ? s1_n : s1_q;
    s2_d   = (s2_en && s1_v_q)   ? s2_n : s2_q;
    s3_d   = (s3_en && s2_v_q)   ? s3_n : s3_q;
  end

  // NOTE: data registers are reset too, so the out_* bus reads zero until the first result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v_q <= 1'b0;
      s2_v_q <= 1'b0;
      s3_v_q <= 1'b0;
      s1_q   <= '0;
      s2_q   <= '0;
      s3_q   <= '0;
    end else begin
      // NOTE: non-blocking updates let every stage sample its neighbour's old value.
      s1_v_q <= s1_v_d;
      s2_v_q <= s2_v_d;
      s3_v_q <= s3_v_d;
      s1_q   <= s1_d;
      s2_q   <= s2_d;
      s3_q   <= s3_d;
    end
  end

  assign in_ready      = s1_en;
  assign out_valid     = s3_v_q;
  assign out_ctr       = s3_q.ctr;
  assign out_ctr_noisy = s3_q.ctr_noisy;
  assign out_n_pepper  = s3_q.pep;
  assign out_n_salt    = s3_q.salt;
  assign out_n_noisy   = s3_q.noisy;
  assign out_clean_sum = s3_q.sum;
  assign out_all_noisy = s3_q.all_noisy;

endmodule
